hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Stall and flush generator paired with the pipeline's operand-forwarding logic. It decides when ID cannot proceed: load-use cases that forwarding cannot cover, or every RAW dependency when forwarding is disabled.
- Keeps a registered shadow of the destinations in flight in EX/MEM/WB, built only from instructions it lets leave ID.
- Drives PC/IF-ID hold, ID/EX bubble insertion, IF/ID flush on taken BZ, and saturating performance counters.

Parameters:
- CNT_W, 16, width of stall_cycles and flush_count counters.
- OP_LD, 10, load opcode.
- OP_BZ, 12, branch-if-zero opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hazard_en  in  1  1 = forwarding disabled (stall on all RAW), 0 = forwarding active.
- freeze  in  1  global pipeline hold (memory wait); scoreboard and counters hold.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  4  opcode in ID.
- id_src1  in  3  first source register (0 = unused / R0).
- id_src2  in  3  second source register or store-data register.
- id_src2_used  in  1  id_src2 is actually read.
- id_writes_reg  in  1  ID instruction writes id_dest.
- id_dest  in  3  destination register.
- branch_taken  in  1  BZ in ID resolved taken.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush_if_id  out  1  replace IF/ID with NOP.
- sb_pending  out  8  bit r = register r is a destination in EX, MEM or WB; bit 0 is always 0.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flushes.

Behaviour:
- Scoreboard: three registered entries, EX/MEM/WB. Each entry holds {valid, dest[2:0], is_ld}. Reset clears all entries, sb_pending=0, and both counters=0. stall and flush_if_id are combinational and are 0 while in reset.
- Advance: on each clk edge with freeze=0:
  - WB<=MEM, MEM<=EX.
  - EX<={1, id_dest, id_opcode==OP_LD} if id_valid & ~stall & id_writes_reg & id_dest!=0. Otherwise EX<=invalid; this is the bubble.
- freeze=1: every register holds. stall/flush outputs still evaluate, but counters do not increment.
- match(X, r): X.valid & r!=0 & X.dest==r.
- Used sources:
  - src1 is used when id_src1!=0.
  - src2 is used when id_src2_used & id_src2!=0.
  - For OP_BZ, only src1 is used.
- stall, with id_valid=1:
  - hazard_en=0: stall=1 if EX.is_ld and match(EX, any used source). MEM and WB loads are forwardable, so no stall.
  - hazard_en=1: stall=1 if match(EX or MEM, any used source). The register file writes before it reads, so a WB match does not stall.
  - id_valid=0 -> stall=0.
- Multi-cycle stalls: a hazard_en=1 dependency on EX stalls 2 cycles (EX then MEM) and is released when the producer reaches WB. A load-use stall with forwarding lasts exactly 1 cycle.
- flush_if_id = branch_taken & id_valid & (id_opcode==OP_BZ) & ~stall. branch_taken while stalled is ignored, because the branch re-evaluates next cycle. The BZ itself advances as a non-writing instruction.
- Counters: increment by 1 when ~freeze and the respective output is 1. They saturate at all-ones with no wrap.
- hazard_en changing mid-stream: takes effect the same cycle; the scoreboard contents are mode-independent.
- rst_n asserted mid-stall: stall drops immediately and the scoreboard empties.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> stall=0, flush_if_id=0, sb_pending=0, counters=0. Release, then 3 idle cycles -> all outputs unchanged.
- Load-use, forwarding on: LD R3 enters ID, next ID=ADD src1=R3, hazard_en=0 -> stall=1 for exactly 1 cycle, sb_pending=8'b0000_1000, stall_cycles=1. An ADD with src1=R3 one cycle later -> no stall.
- Forwarding off: ADDI R5, then ADD src2=R5 (src2_used=1), hazard_en=1 -> stall=1 for 2 cycles, released when R5 is in WB. stall_cycles=2.
- R0 and unused sources: LD R0 then ADD src1=0; also LD R2 then ADD src2=R2 with src2_used=0 -> stall=0 in both modes.
- Branch: BZ src1=R1 with no pending R1, branch_taken=1 -> flush_if_id=1 for 1 cycle, flush_count=1. BZ depending on a LD in EX with branch_taken=1 -> flush=0 while stalled, then flush=1 the next cycle.
- freeze/saturation: freeze=1 during a stall -> scoreboard and stall_cycles hold, stall stays 1. Preload by forcing 0xFFFF stalls with CNT_W=16 -> stall_cycles stays 0xFFFF.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage stall/flush generator with an EX/MEM/WB destination scoreboard
module hazard_stall_unit #(
    parameter int         CNT_W = 16,
    parameter logic [3:0] OP_LD = 4'd10,
    parameter logic [3:0] OP_BZ = 4'd12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_en,
    input  logic             freeze,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [2:0]       id_src1,
    input  logic [2:0]       id_src2,
    input  logic             id_src2_used,
    input  logic             id_writes_reg,
    input  logic [2:0]       id_dest,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush_if_id,
    output logic [7:0]       sb_pending,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
        logic       is_ld;
    } sb_entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sb_entry_t  ex_q;
    sb_entry_t  mem_q;
    sb_entry_t  ex_next;
    // Load status no longer matters once the producer reaches WB.
    logic       wb_valid_q;
    logic [2:0] wb_dest_q;

    logic src1_used;
    logic src2_used;
    logic hit_ex;
    logic hit_mem;
    logic stall_raw;

    function automatic logic entry_match(input logic vld, input logic [2:0] dst,
                                         input logic [2:0] r);
        return vld && (r != 3'd0) && (dst == r);
    endfunction

    always_comb begin
        src1_used = (id_src1 != 3'd0);
        src2_used = id_src2_used && (id_src2 != 3'd0) && (id_opcode != OP_BZ);

        hit_ex  = (src1_used && entry_match(ex_q.valid, ex_q.dest, id_src1)) ||
                  (src2_used && entry_match(ex_q.valid, ex_q.dest, id_src2));
        hit_mem = (src1_used && entry_match(mem_q.valid, mem_q.dest, id_src1)) ||
                  (src2_used && entry_match(mem_q.valid, mem_q.dest, id_src2));

        // WB never stalls: the register file writes before it reads.
        if (hazard_en) begin
            stall_raw = hit_ex || hit_mem;
        end else begin
            stall_raw = hit_ex && ex_q.is_ld;
        end

        stall       = rst_n && id_valid && stall_raw;
        flush_if_id = rst_n && branch_taken && id_valid && (id_opcode == OP_BZ) && !stall;
    end

    always_comb begin
        ex_next = '0;
        if (id_valid && !stall && id_writes_reg && (id_dest != 3'd0)) begin
            ex_next.valid = 1'b1;
            ex_next.dest  = id_dest;
            ex_next.is_ld = (id_opcode == OP_LD);
        end
    end

    always_comb begin
        sb_pending = 8'd0;
        for (int r = 1; r < 8; r++) begin
            sb_pending[r] = entry_match(ex_q.valid, ex_q.dest, 3'(r)) ||
                            entry_match(mem_q.valid, mem_q.dest, 3'(r)) ||
                            entry_match(wb_valid_q, wb_dest_q, 3'(r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= 3'd0;
        end else if (!freeze) begin
            wb_valid_q <= mem_q.valid;
            wb_dest_q  <= mem_q.dest;
            mem_q      <= ex_q;
            ex_q       <= ex_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (!freeze) begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (flush_if_id && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule
